// File: rtl/aqp_ebus_pkg.sv
// Shared definitions for the external-bus initiator.
// Contents: FSM state encoding, T-state length constants and parameter defaults.
package aqp_ebus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_T1      = 3'd2,
        ST_T2      = 3'd3,
        ST_TW      = 3'd4,
        ST_T3      = 3'd5,
        ST_HOLD    = 3'd6
    } ebus_state_t;

    // Base bus-cycle length in phi periods (T1, T2, T3); I/O adds wait states.
    localparam int MEM_CYCLE_PHI      = 3;
    localparam int DEF_IO_WAIT_STATES = 1;
    localparam int DEF_BUSACK_TIMEOUT = 1023;

    localparam int TO_CNT_W   = 10;
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/aqp_sync2.sv
// Two-flop synchroniser for an asynchronous level input.
// Ports: clk, reset (sync, active high), d (async in), q (synchronised out).
module aqp_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aqp_ebus_initiator.sv
// Z80-style external bus initiator: requests the bus with BUSREQ/BUSACK, then
// runs one memory or I/O read/write cycle per command, T-states timed on
// phi_clken. With cmd_keep the bus is held (HOLD) for the next command.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   phi_clken             one-clk pulse per phi period
//   has_z80               0 = no external Z80, do not wait for BUSACK
//   cmd_*                 command handshake and fields (latched on accept)
//   rsp_*                 one-clk response pulse, read data, timeout flag
//   ebus_*                external bus request/ack, address, data, strobes
module aqp_ebus_initiator
    import aqp_ebus_pkg::*;
#(
    parameter int BUSACK_TIMEOUT = DEF_BUSACK_TIMEOUT,
    parameter int IO_WAIT_STATES = DEF_IO_WAIT_STATES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phi_clken,
    input  logic        has_z80,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wrdata,
    input  logic        cmd_write,
    input  logic        cmd_io,
    input  logic        cmd_keep,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rddata,
    output logic        rsp_timeout,
    output logic        ebus_busreq_n,
    input  logic        ebus_busack_n,
    output logic        ebus_en,
    output logic [15:0] ebus_a,
    input  logic [7:0]  ebus_d_in,
    output logic [7:0]  ebus_d_out,
    output logic        ebus_d_oe,
    output logic        ebus_rd_n,
    output logic        ebus_wr_n,
    output logic        ebus_mreq_n,
    output logic        ebus_iorq_n
);

    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(BUSACK_TIMEOUT);

    ebus_state_t           state, state_nxt;
    logic [15:0]           addr_q;
    logic [7:0]            wrdata_q;
    logic                  write_q, io_q, keep_q;
    logic                  pend;       // command accepted in HOLD, waiting for phi
    logic [TO_CNT_W-1:0]   to_cnt;
    logic [WAIT_CNT_W-1:0] wcnt;
    logic                  busack_s;
    logic                  accept, cyc_done, abort, wait_last, strobe_on;

    aqp_sync2 #(.RESET_VAL(1'b1)) u_busack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ebus_busack_n),
        .q     (busack_s)
    );

    assign accept    = cmd_valid && cmd_ready;
    assign wait_last = int'(wcnt) >= IO_WAIT_STATES - 1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state; cyc_done/abort mark the edges that produce a response
    always_comb begin
        state_nxt = state;
        cyc_done  = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE:    if (accept) state_nxt = ST_ACQUIRE;
            ST_ACQUIRE: begin
                if (to_cnt == TO_LIMIT) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (phi_clken && (!busack_s || !has_z80)) begin
                    state_nxt = ST_T1;
                end
            end
            ST_T1:      if (phi_clken) state_nxt = ST_T2;
            ST_T2:      if (phi_clken) state_nxt = (io_q && IO_WAIT_STATES > 0) ? ST_TW : ST_T3;
            ST_TW:      if (phi_clken && wait_last) state_nxt = ST_T3;
            ST_T3: begin
                if (phi_clken) begin
                    cyc_done  = 1'b1;
                    state_nxt = keep_q ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A new command wins over the release condition.
                if (phi_clken) begin
                    if (pend || accept)              state_nxt = ST_T1;
                    else if (!cmd_valid && !cmd_keep) state_nxt = ST_IDLE;
                end
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        cmd_ready     = !reset && (state == ST_IDLE || (state == ST_HOLD && !pend));
        ebus_busreq_n = (state == ST_IDLE);
        ebus_en       = (state != ST_IDLE) && (state != ST_ACQUIRE);
        ebus_d_oe     = write_q && (state == ST_T1 || state == ST_T2 ||
                                    state == ST_TW || state == ST_T3);
        strobe_on     = (state == ST_T2 || state == ST_TW || state == ST_T3);
        ebus_mreq_n   = !(strobe_on && !io_q);
        ebus_iorq_n   = !(strobe_on && io_q);
        ebus_rd_n     = !(strobe_on && !write_q);
        ebus_wr_n     = !(strobe_on && write_q);
    end

    assign ebus_a     = addr_q;
    assign ebus_d_out = wrdata_q;

    // Datapath: command latch, counters, response
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            wrdata_q    <= '0;
            write_q     <= 1'b0;
            io_q        <= 1'b0;
            keep_q      <= 1'b0;
            pend        <= 1'b0;
            to_cnt      <= '0;
            wcnt        <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rddata  <= 8'hFF;
        end else begin
            if (accept) begin
                addr_q   <= cmd_addr;
                wrdata_q <= cmd_wrdata;
                write_q  <= cmd_write;
                io_q     <= cmd_io;
                keep_q   <= cmd_keep;
            end
            pend <= (state == ST_HOLD) && (state_nxt == ST_HOLD) && (pend || accept);

            // Saturating BUSACK wait counter
            if (state == ST_IDLE)
                to_cnt <= '0;
            else if (state == ST_ACQUIRE && phi_clken && to_cnt != TO_LIMIT)
                to_cnt <= to_cnt + 1'b1;

            if (state == ST_T2)                 wcnt <= '0;
            else if (state == ST_TW && phi_clken) wcnt <= wcnt + 1'b1;

            rsp_valid   <= cyc_done || abort;
            rsp_timeout <= abort;
            if (abort)
                rsp_rddata <= 8'hFF;
            else if (cyc_done)
                rsp_rddata <= write_q ? 8'hFF : ebus_d_in;
        end
    end

endmodule

// File: doc/aqp_ebus_initiator.md
Name: aqp_ebus_initiator

Overview:
- Z80-style bus-cycle generator that drives the external bus as initiator.
- It is the counterpart of the core's bus-responder strobe detection: it requests the bus (BUSREQ/BUSACK), then runs memory or I/O read/write cycles timed on the phi clock enable.
- Serves on-chip masters such as ESP-driven RAM/cartridge loading.
- Sits beside the SPI slave and the T80. The top-level mux selects its pins when `ebus_en` is high.

Parameters:
- `BUSACK_TIMEOUT`, 1023: phi periods to wait for BUSACK before aborting the request.
- `IO_WAIT_STATES`, 1: extra wait T-states inserted in I/O cycles (Z80 automatic TW).

Ports:
- `clk` in 1: system clock (28.63636MHz).
- `reset` in 1: synchronous, active-high reset.
- `phi_clken` in 1: one-clk pulse per phi period; all T-state advances happen on it.
- `has_z80` in 1: external Z80 fitted; when 0, BUSACK is not waited for.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_addr` in 16: cycle address.
- `cmd_wrdata` in 8: write data.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_io` in 1: 1 = IORQ cycle, 0 = MREQ cycle.
- `cmd_keep` in 1: keep bus ownership after this cycle.
- `rsp_valid` out 1: one-clk response pulse.
- `rsp_rddata` out 8: read data, valid with `rsp_valid`.
- `rsp_timeout` out 1: response is a BUSACK-timeout abort.
- `ebus_busreq_n` out 1: bus request.
- `ebus_busack_n` in 1: bus acknowledge (asynchronous; 2-flop synchronised).
- `ebus_en` out 1: initiator owns and drives `a`/`rd_n`/`wr_n`/`mreq_n`/`iorq_n`.
- `ebus_a` out 16: address.
- `ebus_d_in` in 8: bus data in.
- `ebus_d_out` out 8: bus data out.
- `ebus_d_oe` out 1: data drive enable.
- `ebus_rd_n`, `ebus_wr_n`, `ebus_mreq_n`, `ebus_iorq_n` out 1 each: strobes.

Behaviour:
- Clocking and reset: one clock `clk`. Reset `reset` is synchronous and active-high.
- Reset values:
  - state IDLE; `cmd_ready` = 0 while `reset` is high.
  - `rsp_valid` = 0, `rsp_timeout` = 0, `rsp_rddata` = 8'hFF.
  - `ebus_busreq_n` = 1, `ebus_en` = 0, `ebus_d_oe` = 0, `ebus_a` = 0, `ebus_d_out` = 0.
  - all strobes = 1.
- Reset mid-cycle: on the reset clk edge, strobes go inactive, the bus is released and no response is issued.
- `cmd_ready` = 1 only in IDLE and HOLD (and not in reset). Command fields are latched on accept.
- States: IDLE, ACQUIRE, T1, T2, TW, T3, HOLD.
  - IDLE, on accept: `ebus_busreq_n` goes to 0 on the next clk; go to ACQUIRE. The timeout counter is cleared.
  - ACQUIRE: on each `phi_clken`, if synchronised busack is low or `has_z80` = 0, go to T1. Otherwise increment the counter.
  - ACQUIRE timeout: when the counter reaches `BUSACK_TIMEOUT`, pulse `rsp_valid` with `rsp_timeout` = 1 and `rsp_rddata` = FF, set `busreq_n` = 1, and return to IDLE.
  - T1 (one phi period): `ebus_en` = 1, `ebus_a` = addr. For writes, `ebus_d_oe` = 1 with data. Strobes inactive.
  - T2: `mreq_n` or `iorq_n` = 0; `rd_n` = 0 (read) or `wr_n` = 0 (write). For memory cycles, next is T3. For I/O cycles, next is TW for `IO_WAIT_STATES` periods (0 skips TW), then T3.
  - T3: strobes held. On the `phi_clken` ending T3:
    - latch `ebus_d_in` into `rsp_rddata` (reads only; writes leave FF);
    - deassert strobes and `ebus_d_oe`;
    - pulse `rsp_valid` (`rsp_timeout` = 0) on the following clk.
  - After T3: if `keep` is set, go to HOLD. Otherwise deassert `ebus_en` and `ebus_busreq_n` together and return to IDLE.
  - HOLD: `ebus_en` = 1, strobes inactive, `busreq_n` = 0.
    - Accepting a command goes to T1 at the next `phi_clken`, without re-arbitrating.
    - `cmd_valid` low with `cmd_keep` low at the HOLD `phi_clken` releases the bus and returns to IDLE.
- Cycle length in phi periods: memory = 3; I/O = 3 + `IO_WAIT_STATES`.
- Address is stable from T1 through the end of T3. Write data is stable from T1 through the T3 end.
- Timeout counter: 10 bits, saturating at `BUSACK_TIMEOUT` (no wrap).
- Simultaneous `cmd_valid` and HOLD-release condition: accept wins.
- `ebus_busack_n` rising during a cycle is ignored until IDLE.

Decomposition:
- Shared package `aqp_ebus_pkg`: state encoding constants; T-state length constants; default `IO_WAIT_STATES` and `BUSACK_TIMEOUT`.
- One sub-module: `aqp_sync2`, a 2-flop synchroniser for `ebus_busack_n`. The FSM and datapath stay in the top module.

Test Plan:
- Reset: hold `reset` 3 clks mid-T2 of a write → next clk shows `busreq_n` = 1, `en` = 0, all strobes 1, `d_oe` = 0, and no `rsp_valid`.
- Memory read, `has_z80` = 0, addr 16'h3800, bus data 8'hA5:
  - `mreq_n`/`rd_n` low for exactly 2 phi periods (T2–T3);
  - one `rsp_valid` with `rddata` A5 and `timeout` 0;
  - `en` drops after 3 phi periods.
- I/O write, `IO_WAIT_STATES` = 1, addr 16'h00FC, data 8'h5A:
  - `iorq_n`/`wr_n` low for 3 phi periods;
  - `d_out` = 5A with `d_oe` from T1 to the T3 end;
  - `rsp_valid` with `rddata` FF.
- BUSACK timeout, `has_z80` = 1, busack held high, `BUSACK_TIMEOUT` = 4:
  - after 4 `phi_clken`, `rsp_valid` with `rsp_timeout` = 1 and `rddata` FF;
  - `busreq_n` returns to 1; strobes never asserted.
- Back-to-back with `cmd_keep` = 1 (3 reads at 0x0000–0x0002, last with keep = 0):
  - `busreq_n` stays low throughout; one ACQUIRE only;
  - 3 responses with correct data; release after the third.
- BUSACK handshake, `has_z80` = 1: busack asserted 7 phi after request → T1 starts within 1 `phi_clken` after the 2-flop sync delay; the cycle completes normally.
